// File: rtl/vecram_arbiter.sv
// vecram_arbiter: shares the vector RAM port among download, CPU and AVG fetch (priority in that order)
module vecram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int ROM_BASE = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dl_wr,
  input  logic [11:0]       dl_addr,
  input  logic [7:0]        dl_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_overrun,
  input  logic              avg_req,
  input  logic [ADDR_W-1:0] avg_addr,
  output logic [15:0]       avg_inst,
  output logic              avg_valid,
  output logic              avg_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);
  typedef enum logic [1:0] {IDLE, HI, LO, DONE} st_t;
  typedef enum logic [1:0] {T_NONE, T_CPU, T_HI, T_LO} tag_t;
  st_t r_st, w_st_nx;
  tag_t r_tag, w_tag;
  logic              r_cpu_pend, r_cpu_we, r_overrun;
  logic [ADDR_W-1:0] r_cpu_addr, r_avg_a, r_ram_addr, w_addr;
  logic [7:0]        r_cpu_wdata, r_cpu_rdata, r_hi, w_wdata;
  logic [15:0]       r_avg_inst;
  logic              w_we, w_avg_act, w_cpu_gnt, w_avg_gnt;
  assign w_avg_act = r_st == HI || r_st == LO;
  assign w_cpu_gnt = !dl_wr && r_cpu_pend;
  assign w_avg_gnt = !dl_wr && !r_cpu_pend && w_avg_act;
  always_comb begin
    w_addr = r_ram_addr;
    w_we = 1'b0;
    w_wdata = r_cpu_wdata;
    w_tag = T_NONE;
    if (dl_wr) begin
      w_we = 1'b1;
      w_addr = ADDR_W'(dl_addr) + ADDR_W'(ROM_BASE);
      w_wdata = dl_data;
    end else if (r_cpu_pend) begin
      w_we = r_cpu_we;
      w_addr = r_cpu_addr;
      w_tag = T_CPU;
    end else if (w_avg_act) begin
      w_addr = r_avg_a | ADDR_W'(r_st == LO);
      w_tag = r_st == LO ? T_LO : T_HI;
    end
  end
  always_comb begin
    w_st_nx = r_st;
    case (r_st)
      IDLE: w_st_nx = avg_req ? HI : IDLE;
      HI:   w_st_nx = w_avg_gnt ? LO : HI;
      LO:   w_st_nx = w_avg_gnt ? DONE : LO;
      DONE: w_st_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= IDLE;
      r_tag <= T_NONE;
      r_cpu_pend <= 1'b0;
      r_cpu_we <= 1'b0;
      r_overrun <= 1'b0;
      r_cpu_addr <= '0;
      r_cpu_wdata <= '0;
      r_cpu_rdata <= '0;
      r_avg_a <= '0;
      r_ram_addr <= '0;
      r_hi <= '0;
      r_avg_inst <= '0;
    end else begin
      r_st <= w_st_nx;
      r_tag <= w_tag;
      r_ram_addr <= w_addr;
      if (w_cpu_gnt) r_cpu_pend <= 1'b0;
      if (cpu_req) begin
        if (r_cpu_pend) r_overrun <= 1'b1;
        else begin
          r_cpu_pend <= 1'b1;
          r_cpu_we <= cpu_we;
          r_cpu_addr <= cpu_addr;
          r_cpu_wdata <= cpu_wdata;
        end
      end
      if (r_tag == T_CPU && !r_cpu_we) r_cpu_rdata <= ram_rdata;
      if (r_st == IDLE && avg_req) r_avg_a <= avg_addr & ~ADDR_W'(1);
      // high byte arrives in the first LO cycle; later LO stalls keep it
      if (r_tag == T_HI) r_hi <= ram_rdata;
      if (r_st == DONE) r_avg_inst <= {r_hi, ram_rdata};
    end
  end
  assign ram_addr = w_addr;
  assign ram_we = w_we && !rst;
  assign ram_wdata = w_wdata;
  assign cpu_ack = r_tag == T_CPU;
  assign cpu_rdata = cpu_ack && !r_cpu_we ? ram_rdata : r_cpu_rdata;
  assign cpu_overrun = r_overrun;
  assign avg_valid = r_st == DONE;
  assign avg_inst = avg_valid ? {r_hi, ram_rdata} : r_avg_inst;
  assign avg_busy = w_avg_act;
endmodule

// File: tb/tb_vecram_arbiter.sv
// tb_vecram_arbiter: directed checks of vecram_arbiter against a behavioural 8K x 8 RAM
module tb_vecram_arbiter;
  logic clk = 0;
  always #5 clk = ~clk;
  logic        rst, dl_wr, cpu_req, cpu_we, cpu_ack, cpu_overrun;
  logic        avg_req, avg_valid, avg_busy, ram_we;
  logic [11:0] dl_addr;
  logic [7:0]  dl_data, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic [12:0] cpu_addr, avg_addr, ram_addr;
  logic [15:0] avg_inst;
  logic [7:0]  mem [0:8191];
  int checks = 0, failures = 0;
  vecram_arbiter dut (
    .clk(clk), .rst(rst), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_overrun(cpu_overrun),
    .avg_req(avg_req), .avg_addr(avg_addr), .avg_inst(avg_inst), .avg_valid(avg_valid),
    .avg_busy(avg_busy), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cpu_access(input logic we, input logic [12:0] a, input logic [7:0] d,
                            output int lat, output logic [7:0] rd);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    tick;
    cpu_req = 0;
    lat = 1;
    @(negedge clk);
    while (!cpu_ack && lat < 20) begin
      tick;
      lat++;
      @(negedge clk);
    end
    chk("cpu_ack_seen", cpu_ack, 1);
    rd = cpu_rdata;
  endtask
  task automatic avg_fetch(input logic [12:0] a, output int lat, output logic [15:0] ins);
    avg_req = 1; avg_addr = a;
    tick;
    avg_req = 0;
    lat = 1;
    @(negedge clk);
    chk("avg_busy_start", avg_busy, 1);
    while (!avg_valid && lat < 20) begin
      tick;
      lat++;
      @(negedge clk);
    end
    chk("avg_valid_seen", avg_valid, 1);
    ins = avg_inst;
  endtask
  initial begin
    int lat, nack, nval, ack_cyc, val_cyc;
    logic [7:0] rd;
    logic [15:0] ins;
    rst = 1; dl_wr = 1; dl_addr = 12'h005; dl_data = 8'hEE;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; avg_req = 0; avg_addr = 0;
    @(negedge clk);
    chk("ram_we_in_reset", ram_we, 0);
    tick;
    dl_wr = 0;
    tick;
    rst = 0;
    repeat (10) tick;
    @(negedge clk);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_overrun", cpu_overrun, 0);
    chk("rst_avg_inst", avg_inst, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_avg_busy", avg_busy, 0);
    chk("rst_ram_we", ram_we, 0);
    dl_wr = 1; dl_addr = 12'h005; dl_data = 8'hAB;
    @(negedge clk);
    chk("dl_we", ram_we, 1);
    chk("dl_addr", ram_addr, 13'h1005);
    chk("dl_data", ram_wdata, 8'hAB);
    tick;
    dl_addr = 12'h004; dl_data = 8'hC3;
    tick;
    dl_addr = 12'hFFF; dl_data = 8'h11;
    @(negedge clk);
    chk("dl_addr_top", ram_addr, 13'h1FFF);
    tick;
    dl_wr = 0;
    cpu_access(1, 13'h0100, 8'h5A, lat, rd);
    chk("cpu_wr_lat", lat, 2);
    cpu_access(0, 13'h0100, 8'h00, lat, rd);
    chk("cpu_rd_lat", lat, 2);
    chk("cpu_rd_data", rd, 8'h5A);
    tick;
    @(negedge clk);
    chk("cpu_ack_pulse", cpu_ack, 0);
    chk("cpu_rdata_held", cpu_rdata, 8'h5A);
    cpu_access(1, 13'h0200, 8'h12, lat, rd);
    cpu_access(1, 13'h0201, 8'h34, lat, rd);
    avg_fetch(13'h0201, lat, ins);
    chk("avg_lat", lat, 3);
    chk("avg_inst", ins, 16'h1234);
    tick;
    @(negedge clk);
    chk("avg_valid_pulse", avg_valid, 0);
    chk("avg_inst_held", avg_inst, 16'h1234);
    chk("avg_busy_done", avg_busy, 0);
    avg_fetch(13'h1005, lat, ins);
    chk("avg_rom_inst", ins, 16'hC3AB);
    tick;
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0100; avg_req = 1; avg_addr = 13'h0200;
    tick;
    cpu_req = 0; avg_req = 0;
    nack = 0; nval = 0; ack_cyc = 0; val_cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      dl_wr = i <= 3; dl_addr = 12'h010 + 12'(i); dl_data = 8'h70 + 8'(i);
      @(negedge clk);
      if (cpu_ack) begin nack++; ack_cyc = i; rd = cpu_rdata; end
      if (avg_valid) begin nval++; val_cyc = i; ins = avg_inst; end
      tick;
    end
    chk("mix_ack_cycle", ack_cyc, 5);
    chk("mix_valid_cycle", val_cyc, 7);
    chk("mix_ack_count", nack, 1);
    chk("mix_valid_count", nval, 1);
    chk("mix_cpu_rdata", rd, 8'h5A);
    chk("mix_avg_inst", ins, 16'h1234);
    cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0100;
    tick;
    tick;
    cpu_req = 0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ack) nack++;
      tick;
    end
    chk("ovr_ack_count", nack, 1);
    chk("ovr_flag", cpu_overrun, 1);
    cpu_access(0, 13'h0201, 8'h00, lat, rd);
    chk("ovr_next_rd", rd, 8'h34);
    chk("ovr_sticky", cpu_overrun, 1);
    tick;
    avg_req = 1; avg_addr = 13'h0200;
    tick;
    avg_req = 0;
    tick;
    dl_wr = 1; dl_addr = 12'h020;
    @(negedge clk);
    chk("stall_busy", avg_busy, 1);
    chk("stall_valid", avg_valid, 0);
    tick;
    rst = 1;
    tick;
    @(negedge clk);
    chk("rst_mid_we", ram_we, 0);
    dl_wr = 0;
    tick;
    rst = 0;
    nval = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (avg_valid) nval++;
      tick;
    end
    chk("rst_no_valid", nval, 0);
    chk("rst_busy_clr", avg_busy, 0);
    chk("rst_ovr_clr", cpu_overrun, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
